// File: rtl/gamma_linearize.sv
// Gamma 2.2 decoder: maps gamma-encoded RGB in an HDMI pixel pack back to linear light.
// Two-cycle pipeline with a runtime-writable 256x8 LUT, loaded with the default curve after reset.
module gamma_linearize #(
  parameter int unsigned  H_ACT     = 1280,
  parameter int unsigned  V_ACT     = 720,
  localparam int unsigned XW        = $clog2(H_ACT),
  localparam int unsigned YW        = $clog2(V_ACT),
  localparam int unsigned PACK_SIZE = 3 * 8 + 4 + XW + YW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 lut_we,
  input  logic [7:0]           lut_addr,
  input  logic [7:0]           lut_wdata,
  output logic                 lut_busy,
  output logic                 active,
  input  logic [PACK_SIZE-1:0] i_pack,
  output logic [PACK_SIZE-1:0] o_pack
);

  // Pack layout, MSB first: {clk, hsync, vsync, de, x, y, r, g, b}
  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
  } pix_t;

  typedef enum logic {StInit, StRun} state_e;

  function automatic logic [2047:0] gen_default();
    logic [2047:0] tbl;
    real           v;
    tbl = '0;
    for (int i = 0; i < 256; i++) begin
      v = 255.0 * ((real'(i) / 255.0) ** 2.2);
      tbl[i*8 +: 8] = 8'($rtoi(v + 0.5));
    end
    return tbl;
  endfunction

  localparam logic [2047:0] DEFAULT_TBL = gen_default();

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT owns the write port; user writes are only honoured in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = lut_addr;
    mem_wdata = lut_wdata;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = DEFAULT_TBL[{cnt_q, 3'b000} +: 8];
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'd255) state_d = StRun;
      end
      StRun: begin
        mem_we = lut_we;
      end
      default: state_d = StInit;
    endcase
  end

  assign lut_busy = (state_q == StInit);

  pix_t in_pix, s1_q, s2_q, out_pix;
  logic vs_q, active_q, s1_tag_q, s2_tag_q, tag_d;

  assign in_pix = pix_t'(i_pack[PACK_SIZE-2:0]);

  // The boundary pixel itself already carries the newly sampled enable.
  assign tag_d  = (in_pix.vsync && !vs_q) ? (en && (state_q == StRun)) : active_q;
  assign active = active_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q     <= 1'b0;
      active_q <= 1'b0;
      s1_q     <= '0;
      s1_tag_q <= 1'b0;
      s2_q     <= '0;
      s2_tag_q <= 1'b0;
    end else begin
      vs_q     <= in_pix.vsync;
      active_q <= tag_d;
      s1_q     <= in_pix;
      s1_tag_q <= tag_d;
      s2_q     <= s1_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  logic [7:0] lut_q [256];
  logic [7:0] rd_r_q, rd_g_q, rd_b_q;

  // Non-blocking write gives old data on a same-address read in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) lut_q[mem_waddr] <= mem_wdata;
    rd_r_q <= lut_q[s1_q.r];
    rd_g_q <= lut_q[s1_q.g];
    rd_b_q <= lut_q[s1_q.b];
  end

  always_comb begin
    out_pix = s2_q;
    if (s2_tag_q) begin
      out_pix.r = rd_r_q;
      out_pix.g = rd_g_q;
      out_pix.b = rd_b_q;
    end
  end

  assign o_pack = {i_pack[PACK_SIZE-1], out_pix};

endmodule

// File: tb/tb_gamma_linearize.sv
// Self-checking bench for gamma_linearize: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the LUT, frame gating and latency.
module tb_gamma_linearize;

  localparam int PACK_SIZE = 49;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pix_t;

  logic                 clk = 1'b0;
  logic                 rstn, en, lut_we, lut_busy, active;
  logic [7:0]           lut_addr, lut_wdata;
  pix_t                 in_pix, out_pix;
  logic [PACK_SIZE-1:0] i_pack, o_pack;

  assign i_pack  = {clk, in_pix};
  assign out_pix = pix_t'(o_pack[PACK_SIZE-2:0]);

  always #5 clk = ~clk;

  gamma_linearize dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .lut_we   (lut_we),
    .lut_addr (lut_addr),
    .lut_wdata(lut_wdata),
    .lut_busy (lut_busy),
    .active   (active),
    .i_pack   (i_pack),
    .o_pack   (o_pack)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   tbl   [256];
  int   def_m [256];
  bit   m_init, m_active, m_prev_vs, m_pend_tag;
  int   m_cnt;
  pix_t m_pend, m_out;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_init     = 1'b1;
    m_cnt      = 0;
    m_active   = 1'b0;
    m_prev_vs  = 1'b0;
    m_pend     = '0;
    m_pend_tag = 1'b0;
    m_out      = '0;
  endfunction

  // One clock edge of the spec's behaviour: output the pixel accepted last edge
  // (looked up in the table as it stood before this edge's write), then update.
  function automatic void model_edge();
    bit run;
    if (!rstn) begin
      model_reset();
      return;
    end
    run   = !m_init;
    m_out = m_pend;
    if (m_pend_tag) begin
      m_out.r = 8'(tbl[m_pend.r]);
      m_out.g = 8'(tbl[m_pend.g]);
      m_out.b = 8'(tbl[m_pend.b]);
    end
    if (m_init) begin
      tbl[m_cnt] = def_m[m_cnt];
      m_cnt++;
      if (m_cnt == 256) m_init = 1'b0;
    end else if (lut_we) begin
      tbl[lut_addr] = int'(lut_wdata);
    end
    if (in_pix.vs && !m_prev_vs) m_active = en && run;
    m_prev_vs  = in_pix.vs;
    m_pend     = in_pix;
    m_pend_tag = m_active;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pack", o_pack[PACK_SIZE-2:0], m_out);
    chk("busy", 48'(lut_busy), 48'(m_init));
    chk("active", 48'(active), 48'(m_active));
  endtask

  task automatic set_pix(input bit vs, input bit de, input int x, input int y,
                         input int r, input int g, input int b);
    in_pix.hs = 1'b0;
    in_pix.vs = vs;
    in_pix.de = de;
    in_pix.x  = 11'(x);
    in_pix.y  = 10'(y);
    in_pix.r  = 8'(r);
    in_pix.g  = 8'(g);
    in_pix.b  = 8'(b);
  endtask

  task automatic wait_init();
    int n = 0;
    while (lut_busy && n < 300) begin
      n++;
      tick();
    end
    chk("busy_len", 48'(n), 48'd256);
  endtask

  task automatic frame_start();
    set_pix(1, 0, 0, 0, 0, 0, 0);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) def_m[i] = $rtoi(255.0 * ((real'(i) / 255.0) ** 2.2) + 0.5);
    for (int i = 0; i < 256; i++) tbl[i] = 0;
    model_reset();

    // T1: reset with random input
    rstn = 1'b0; en = 1'b0; lut_we = 1'b0; lut_addr = 8'd0; lut_wdata = 8'd0;
    in_pix = '0;
    for (int i = 0; i < 5; i++) begin
      in_pix = pix_t'({$urandom, $urandom});
      tick();
      chk("t1_rst_zero", o_pack[PACK_SIZE-2:0], 48'd0);
    end
    chk("clk_pass", 48'(o_pack[PACK_SIZE-1]), 48'(clk));
    set_pix(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    // Writes during INIT must be dropped
    lut_we = 1'b1; lut_addr = 8'd128; lut_wdata = 8'd200;
    wait_init();
    lut_we = 1'b0;

    // T2: default curve
    en = 1'b1;
    frame_start();
    set_pix(0, 1, 10, 3, 128, 64, 255);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_r", 48'(out_pix.r), 48'd56);
    chk("t2_g", 48'(out_pix.g), 48'd12);
    chk("t2_b", 48'(out_pix.b), 48'd255);
    chk("t2_de", 48'(out_pix.de), 48'd1);
    chk("t2_x", 48'(out_pix.x), 48'd10);
    chk("t2_y", 48'(out_pix.y), 48'd3);

    // T3: en dropped mid-frame only takes effect at the next vsync rise
    en = 1'b0;
    set_pix(0, 1, 1, 3, 128, 0, 0);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_still_lin", 48'(out_pix.r), 48'd56);
    frame_start();
    set_pix(0, 1, 0, 0, 128, 0, 0);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_bypass", 48'(out_pix.r), 48'd128);
    chk("t3_active", 48'(active), 48'd0);

    // T4: runtime LUT write
    en = 1'b1;
    frame_start();
    lut_we = 1'b1; lut_addr = 8'd128; lut_wdata = 8'd200;
    tick();
    lut_we = 1'b0;
    frame_start();
    set_pix(0, 1, 0, 0, 128, 0, 0);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_custom", 48'(out_pix.r), 48'd200);

    // T5: write coincides with the LUT read of the first r=64 pixel
    set_pix(0, 1, 5, 0, 64, 0, 0);
    tick();
    set_pix(0, 1, 6, 0, 64, 0, 0);
    lut_we = 1'b1; lut_addr = 8'd64; lut_wdata = 8'd99;
    tick();
    chk("t5_old", 48'(out_pix.r), 48'd12);
    lut_we = 1'b0;
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_new", 48'(out_pix.r), 48'd99);

    // T6: asynchronous mid-frame reset restores default table
    set_pix(0, 1, 7, 0, 128, 1, 2);
    tick();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_zero", o_pack[PACK_SIZE-2:0], 48'd0);
    chk("t6_rst_busy", 48'(lut_busy), 48'd1);
    chk("t6_rst_active", 48'(active), 48'd0);
    tick();
    tick();
    rstn = 1'b1;
    wait_init();
    frame_start();
    set_pix(0, 1, 0, 0, 128, 64, 0);
    tick();
    set_pix(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t6_default_r", 48'(out_pix.r), 48'd56);
    chk("t6_default_g", 48'(out_pix.g), 48'd12);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_pix    = pix_t'({$urandom, $urandom});
      in_pix.vs = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      lut_we    = ($urandom_range(0, 5) == 0);
      lut_addr  = 8'($urandom);
      lut_wdata = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
